instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Turns a stream of instruction fields into 32-bit machine words and writes
// them into an instruction memory at consecutive word addresses from 0.
//
// The encoder packs each accepted instruction into its machine word and pushes
// it into a small FIFO. The writer pops one word per cycle and presents it on
// the registered memory-write port. Loading ends in STOP once the HLT word has
// been written. It also ends in STOP if an illegal class is seen, or if the
// address space is exhausted while a word is still waiting.
//
// Parameters
//   ADDR_W      instruction-memory word-address width
//   FIFO_DEPTH  encoded-word buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse: clear everything and begin a load
//   in_valid / in_ready   handshake for the in_* instruction fields
//   in_class              0=ADD 1=ADDI 2=SW 3=BEQZ 4=HLT, 5..7 illegal
//   in_rs, in_rt, in_rd   register fields
//   in_imm                16-bit immediate
//   imem_we/addr/wdata    registered instruction-memory write port
//   busy                  state is LOAD or DRAIN
//   done                  sticky, HLT word written
//   err                   sticky, illegal class or address overflow
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001001;
  localparam logic [5:0] OP_SW   = 6'b001000;
  localparam logic [5:0] OP_BEQZ = 6'b001101;
  localparam logic [5:0] OP_HLT  = 6'b000101;

  localparam logic [2:0] CLS_HLT = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Class codes 0..4 are the only legal ones.
  function automatic logic class_legal(input logic [2:0] cls);
    return (cls <= CLS_HLT);
  endfunction

  // Pack the instruction fields into a machine word. Illegal classes yield 0,
  // but that word is never pushed.
  function automatic logic [31:0] encode(
    input logic [2:0]  cls,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [31:0] w;
    w = 32'd0;
    case (cls)
      3'd0:    w = {OP_ADD,  rs, rt, rd, 11'b0};
      3'd1:    w = {OP_ADDI, rs, rt, imm};
      3'd2:    w = {OP_SW,   rs, rt, imm};
      3'd3:    w = {OP_BEQZ, rs, 5'b0, imm};   // rt is ignored for BEQZ
      3'd4:    w = {OP_HLT,  26'b0};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  // One extra bit so the counter can sit at 2^ADDR_W after the last address
  // without wrapping back to 0.
  logic [ADDR_W:0]   wr_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              hs_p0;
  logic              legal_p0;
  logic              is_hlt_p0;
  logic              vld_p0;
  logic [31:0]       word_p0;
  logic              active;
  logic              pop_req;
  logic              addr_exhausted;
  logic              vld_p1;
  logic              overflow;
  logic [31:0]       head_word;
  logic              head_is_hlt;

  // ---- stage p0: accept and encode the incoming instruction ----
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);

  // A pop in the same cycle does not free space for the input: full means
  // not ready. start also blocks acceptance.
  assign in_ready  = (state == LOAD) && !fifo_full && !err && !start;
  assign hs_p0     = in_valid && in_ready;
  assign legal_p0  = class_legal(in_class);
  assign is_hlt_p0 = (in_class == CLS_HLT);
  assign vld_p0    = hs_p0 && legal_p0;
  assign word_p0   = encode(in_class, in_rs, in_rt, in_rd, in_imm);

  // ---- stage p1: pop from the FIFO and drive the memory write ----
  assign active         = (state == LOAD) || (state == DRAIN);
  assign pop_req        = active && !fifo_empty && !start;
  assign addr_exhausted = wr_cnt[ADDR_W];
  assign vld_p1         = pop_req && !addr_exhausted;
  // A word is still waiting, but the last address has already been used.
  assign overflow       = pop_req && addr_exhausted;
  assign head_word      = fifo_mem[rd_ptr];
  assign head_is_hlt    = (head_word[31:26] == OP_HLT);

  assign busy = active;

  // FIFO storage is pure data; the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      fifo_mem[wr_ptr] <= word_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_cnt     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (start) begin
      // A restart discards any buffered words and any pending write.
      // The memory address and data outputs keep their last values.
      state   <= LOAD;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_cnt  <= '0;
      imem_we <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      imem_we <= vld_p1;

      if (vld_p0) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (vld_p1) begin
        rd_ptr     <= rd_ptr + 1'b1;
        imem_addr  <= wr_cnt[ADDR_W-1:0];
        imem_wdata <= head_word;
        wr_cnt     <= wr_cnt + 1'b1;
        if (head_is_hlt) begin
          done <= 1'b1;
        end
      end

      count <= count + {{PTR_W{1'b0}}, vld_p0} - {{PTR_W{1'b0}}, vld_p1};

      if ((hs_p0 && !legal_p0) || overflow) begin
        err <= 1'b1;
      end

      case (state)
        LOAD: begin
          if (hs_p0 && !legal_p0) begin
            state <= STOP;
          end else if (hs_p0 && is_hlt_p0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p1 && head_is_hlt) begin
            state <= STOP;
          end
        end
        default: state <= state;
      endcase

      // Exhausting the address space ends the load regardless of the above.
      if (overflow) begin
        state <= STOP;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Scoreboard bench for instr_encoder. The stimulus side computes the expected
// machine word from the class/opcode rules with plain arithmetic. It queues
// that word whenever a handshake is about to happen. The monitor pops one
// entry per observed memory write and checks the data, the address (a simple
// running index) and the done timing.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int AW = 6;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [31:0] word;
    int          due;   // cycle the write must appear in, -1 = not timed
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   wr_idx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference encoding: opcode value times 2^26 plus the shifted fields.
  function automatic logic [31:0] model(input int c, input int rs, input int rt,
                                        input int rd, input int imm);
    longint op;
    longint w;
    case (c)
      0:       op = 0;
      1:       op = 9;
      2:       op = 8;
      3:       op = 13;
      default: op = 5;
    endcase
    w = op * 64'd67108864;
    if (c == 0)                w = w + rs * 2097152 + rt * 65536 + rd * 2048;
    else if (c == 1 || c == 2) w = w + rs * 2097152 + rt * 65536 + imm;
    else if (c == 3)           w = w + rs * 2097152 + imm;
    return w[31:0];
  endfunction

  // Monitor: one scoreboard entry per memory write.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready_outside_load", {31'd0, in_ready & ~busy}, 32'd0);
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: actual addr=%0d data=%h required=no write",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", imem_wdata, e.word);
          chk("addr", {26'd0, imem_addr}, wr_idx);
          if (e.due >= 0) chk("latency_cycle", cyc, e.due);
          chk("done_with_write", {31'd0, done}, {31'd0, (e.word[31:26] == 6'd5)});
          wr_idx++;
        end
      end
    end
  end

  // Present one instruction for one clock edge; queue the expected word if it
  // will be accepted. in_valid stays high until idle() drops it.
  task automatic drive(input int c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    exp_t e;
    @(negedge clk);
    #2;
    in_class = 3'(c);
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_valid = 1'b1;
    #1;
    if (in_ready && c <= 4) begin
      e.word = model(c, int'(rs), int'(rt), int'(rd), int'(imm));
      e.due  = (exp_q.size() == 0) ? cyc + 2 : -1;
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // start pulse with a legal instruction offered at the same time; it must
  // not be taken.
  task automatic do_start();
    @(negedge clk);
    #2;
    exp_q.delete();
    wr_idx   = 0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_class = 3'($urandom_range(0, 3));
    in_rs    = 5'($urandom);
    in_imm   = 16'($urandom);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_end(input string tag, input int nwr, input logic d,
                         input logic e_flag);
    chk({tag, "_writes"}, wr_idx, nwr);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_flag});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", {26'd0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b1;

    // IDLE after reset: offered words are not taken and nothing is written.
    repeat (4) drive(0, 5'd1, 5'd2, 5'd3, 16'd0);
    idle(2);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_writes", wr_idx, 0);

    // Directed program with spec-given words (constants, not the model).
    do_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    drive(0, 5'd1, 5'd2, 5'd3, 16'd0);
    idle(3);
    chk("add_word_seen", wr_idx, 1);
    chk("hold_addr", {26'd0, imem_addr}, 32'd0);
    chk("hold_wdata", imem_wdata, 32'h0022_1800);
    drive(1, 5'd1, 5'd2, 5'd0, 16'h0005);
    drive(3, 5'd4, 5'd7, 5'd0, 16'hFFFC);
    drive(4, 5'd0, 5'd0, 5'd0, 16'd0);
    repeat (4) drive_rand();     // after HLT: must not be accepted
    idle(4);
    chk_end("prog1", 4, 1'b1, 1'b0);
    chk("prog1_last_addr", {26'd0, imem_addr}, 32'd3);
    chk("prog1_last_wdata", imem_wdata, 32'h1400_0000);
    chk("prog1_leftover", exp_q.size(), 0);

    // in_valid held high for six SW words with the writer draining.
    do_start();
    for (int i = 0; i < 6; i++)
      drive(2, 5'($urandom), 5'($urandom), 5'd0, 16'($urandom));
    drive(4, 5'd0, 5'd0, 5'd0, 16'd0);
    idle(4);
    chk_end("sw6", 7, 1'b1, 1'b0);

    // Random programs, with and without gaps.
    for (int p = 0; p < 3; p++) begin
      int n;
      n = $urandom_range(5, 20);
      do_start();
      for (int i = 0; i < n; i++) begin
        if (p != 0 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        drive_rand();
      end
      drive(4, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      idle(4);
      chk_end("rand", n + 1, 1'b1, 1'b0);
      chk("rand_leftover", exp_q.size(), 0);
    end

    // Illegal class.
    do_start();
    drive(6, 5'd1, 5'd2, 5'd3, 16'h1234);
    idle(4);
    chk_end("illegal", 0, 1'b0, 1'b1);

    // Restart in the middle of a load: the pending word must be dropped.
    do_start();
    drive(0, 5'd9, 5'd9, 5'd9, 16'd0);
    do_start();
    drive(1, 5'd3, 5'd4, 5'd0, 16'h00AA);
    drive(4, 5'd0, 5'd0, 5'd0, 16'd0);
    idle(4);
    chk_end("restart", 2, 1'b1, 1'b0);

    // Address overflow: only NW words fit.
    do_start();
    for (int i = 0; i < NW + 6; i++) drive_rand();
    drive(4, 5'd0, 5'd0, 5'd0, 16'd0);
    idle(4);
    chk_end("ovf", NW, 1'b0, 1'b1);
    chk("ovf_pending_kept", {31'd0, exp_q.size() > 0}, 32'd1);
    chk("ovf_last_addr", {26'd0, imem_addr}, NW - 1);

    // Reset during a load: outputs drop at once, nothing stale afterwards.
    do_start();
    drive(0, 5'd1, 5'd2, 5'd3, 16'd0);
    drive(0, 5'd4, 5'd5, 5'd6, 16'd0);
    drive(0, 5'd7, 5'd8, 5'd9, 16'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    wr_idx = 0;
    #1;
    chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
    chk("mid_rst_addr", {26'd0, imem_addr}, 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    do_start();
    drive(2, 5'd10, 5'd11, 5'd0, 16'h0F0F);
    drive(4, 5'd0, 5'd0, 5'd0, 16'd0);
    idle(4);
    chk_end("post_rst", 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
